// File: rtl/divider_control_if.sv
// Handshake and datapath-control bundle between the divider controller,
// the restoring-divider datapath and the requesting system.
interface divider_control_if;
    logic       start;
    logic       sign;
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        input  sign,
        output load,
        output add,
        output shift,
        output inbit,
        output sel,
        output busy,
        output done
    );

    modport slave (
        output start,
        output sign,
        input  load,
        input  add,
        input  shift,
        input  inbit,
        input  sel,
        input  busy,
        input  done
    );
endinterface

// File: rtl/divider_control.sv
// Control FSM for an 8-bit / 7-bit restoring divider: one quotient bit per
// DIV cycle, using non-performing restoration driven by the adder sign.
module divider_control #(
    parameter int NBITS = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    divider_control_if.master bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = DIV;
                cnt_d   = '0;
            end
            DIV: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode from the registered state; only sel/inbit in DIV follow sign.
    always_comb begin
        bus.load  = 1'b0;
        bus.add   = 1'b0;
        bus.shift = 1'b0;
        bus.inbit = 1'b0;
        bus.sel   = 2'd3;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            LOAD: begin
                bus.load  = 1'b1;
                bus.sel   = 2'd2;
                bus.shift = 1'b1;
                bus.busy  = 1'b1;
            end
            DIV: begin
                bus.shift = 1'b1;
                bus.busy  = 1'b1;
                if (bus.sign) begin
                    bus.sel   = 2'd3;
                    bus.inbit = 1'b0;
                end else begin
                    bus.sel   = 2'd1;
                    bus.inbit = 1'b1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.sel = 2'd3;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control: behavioural restoring-divider datapath plus a
// scoreboard of hand-computed quotient/remainder/done-cycle expectations.
module tb_divider_control;

    typedef struct {
        logic [7:0] q;
        logic [6:0] r;
        bit         chkR;
        int         doneCyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [7:0] dividendIn = 8'd0;
    logic [6:0] divisorIn = 7'd0;
    logic [7:0] divReg = 8'd0;
    logic [15:0] remReg = 16'd0;
    logic [15:0] muxOut;
    logic [8:0] diff;
    int cyc = 0;
    int assertCount = 0;
    int failCount = 0;
    exp_t sb[$];

    divider_control_if bus ();

    divider_control #(.NBITS(8), .CNT_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: 9-bit subtract so sign is exact even for divisor 0.
    assign diff = {1'b0, remReg[15:8]} - {1'b0, divReg};
    assign bus.sign = diff[8];

    always_comb begin
        muxOut = remReg;
        case (bus.sel)
            2'd1: muxOut = {diff[7:0], remReg[7:0]};
            2'd2: muxOut = {8'h00, dividendIn};
            default: muxOut = remReg;
        endcase
    end

    always @(posedge clk) begin
        if (bus.load) divReg <= {1'b0, divisorIn};
        remReg <= bus.shift ? {muxOut[14:0], bus.inbit} : muxOut;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".load"}, int'(bus.load), 0);
        checkOutput({tag, ".add"}, int'(bus.add), 0);
        checkOutput({tag, ".shift"}, int'(bus.shift), 0);
        checkOutput({tag, ".inbit"}, int'(bus.inbit), 0);
        checkOutput({tag, ".sel"}, int'(bus.sel), 3);
        checkOutput({tag, ".busy"}, int'(bus.busy), 0);
        checkOutput({tag, ".done"}, int'(bus.done), 0);
    endtask

    task automatic applyStimulus(input logic [7:0] dvd, input logic [6:0] dvs,
                                 input logic [7:0] q, input logic [6:0] r, input bit chkR);
        exp_t e;
        @(posedge clk); #1;
        dividendIn = dvd;
        divisorIn  = dvs;
        bus.start  = 1'b1;
        e.q = q; e.r = r; e.chkR = chkR; e.doneCyc = cyc + 10;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Monitor: per-operation busy/DIV run lengths, inbit trace and Mealy checks.
    initial begin
        int busyRun;
        int divRun;
        logic [7:0] inbitSeq;
        exp_t e;
        busyRun = 0;
        divRun = 0;
        inbitSeq = 8'd0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busyRun = 0;
                divRun = 0;
                inbitSeq = 8'd0;
                checkOutput("doneInReset", int'(bus.done), 0);
            end else begin
                if (bus.busy) busyRun++;
                if (bus.busy && !bus.load) begin
                    divRun++;
                    inbitSeq = {inbitSeq[6:0], bus.inbit};
                    checkOutput("divSel", int'(bus.sel), bus.sign ? 3 : 1);
                    checkOutput("divInbit", int'(bus.inbit), bus.sign ? 0 : 1);
                    checkOutput("divAdd", int'(bus.add), 0);
                    checkOutput("divShift", int'(bus.shift), 1);
                end
                if (bus.done) begin
                    checkOutput("doneBusy", int'(bus.busy), 0);
                    checkOutput("doneSel", int'(bus.sel), 3);
                    checkOutput("doneShift", int'(bus.shift), 0);
                    if (sb.size() == 0) begin
                        checkOutput("unexpectedDone", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("doneCycle", cyc, e.doneCyc);
                        checkOutput("quotient", int'(remReg[7:0]), int'(e.q));
                        if (e.chkR) checkOutput("remainder", int'(remReg[15:9]), int'(e.r));
                        checkOutput("inbitTrace", int'(inbitSeq), int'(e.q));
                        checkOutput("busyCycles", busyRun, 9);
                        checkOutput("divCycles", divRun, 8);
                    end
                    busyRun = 0;
                    divRun = 0;
                    inbitSeq = 8'd0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.start = 1'b0;
        #3;
        checkResetOutputs("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        applyStimulus(8'd200, 7'd7, 8'd28, 7'd4, 1'b1);
        repeat (11) @(posedge clk);
        applyStimulus(8'd255, 7'd1, 8'd255, 7'd0, 1'b1);
        repeat (11) @(posedge clk);
        applyStimulus(8'd5, 7'd127, 8'd0, 7'd5, 1'b1);
        repeat (11) @(posedge clk);
        applyStimulus(8'd13, 7'd3, 8'd4, 7'd1, 1'b1);
        repeat (11) @(posedge clk);

        // Stray starts in mid-DIV, the last DIV cycle and DONE must be ignored.
        applyStimulus(8'd150, 7'd11, 8'd13, 7'd7, 1'b1);
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(posedge clk);

        // start held high: two divisions with done pulses 11 cycles apart.
        @(posedge clk); #1;
        dividendIn = 8'd77;
        divisorIn  = 7'd5;
        bus.start  = 1'b1;
        e.q = 8'd15; e.r = 7'd2; e.chkR = 1'b1; e.doneCyc = cyc + 10;
        sb.push_back(e);
        e.doneCyc = cyc + 21;
        sb.push_back(e);
        repeat (12) @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (12) @(posedge clk);

        // Reset during DIV with counter at 4: outputs fall back without a clock edge.
        applyStimulus(8'd99, 7'd4, 8'd24, 7'd3, 1'b1);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1 checkResetOutputs("midReset");
        if (sb.size() > 0) sb.delete(sb.size() - 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        applyStimulus(8'd100, 7'd9, 8'd11, 7'd1, 1'b1);
        repeat (11) @(posedge clk);
        applyStimulus(8'd42, 7'd0, 8'hFF, 7'd0, 1'b0);
        repeat (14) @(posedge clk);

        checkOutput("pendingResults", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
